sha_core_arbiter: RTL

Round-robin arbiter and sequencer that shares one SHA-256 hash core among NREQ miner lanes. It grants the core to one requester and drives the core's input-mux select. It then pulses the core start, waits for the done indication or a timeout, and returns a one-cycle acknowledge to the served lane. It sits between the per-lane miner controllers and the single shared hash datapath.

---
 rtl/sha_core_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sha_core_arbiter.sv
// sha_core_arbiter: shares one SHA-256 core among NREQ miner lanes.
// A round-robin pick in IDLE loads a one-hot grant and a binary mux select.
// The arbiter then pulses the core start and waits in BUSY for done or a
// timeout, and finally acknowledges the owner for one cycle in DONE.
// All outputs are decoded from registered state only, so there is no
// combinational path from i_req or i_hash_done to any output.
module sha_core_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NREQ-1:0]          i_req,
  input  logic                     i_hash_done,
  output logic [NREQ-1:0]          o_grant,
  output logic [$clog2(NREQ)-1:0]  o_sel,
  output logic                     o_hash_start,
  output logic [NREQ-1:0]          o_ack,
  output logic                     o_timeout_err,
  output logic                     o_busy
);

  localparam int SELW = $clog2(NREQ);
  localparam int TW   = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [SELW-1:0] SEL_LAST   = SELW'(NREQ - 1);

  logic [1:0]      r_state;
  logic [NREQ-1:0] r_grant;
  logic [SELW-1:0] r_sel;
  logic [SELW-1:0] r_ptr;
  logic [TW-1:0]   r_timer;
  logic            r_err;

  logic            w_found;
  logic [SELW-1:0] w_pick_sel;
  logic [NREQ-1:0] w_pick_grant;
  logic [SELW-1:0] w_ptr_next;
  int              w_idx;

  // Round-robin search: first requesting lane at r_ptr, r_ptr+1, ... (mod NREQ)
  always_comb begin
    w_found    = 1'b0;
    w_pick_sel = '0;
    w_idx      = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = (int'(r_ptr) + i) % NREQ;
      if (!w_found && i_req[SELW'(w_idx)]) begin
        w_found    = 1'b1;
        w_pick_sel = SELW'(w_idx);
      end else begin
        w_found    = w_found;
      end
    end
  end

  assign w_pick_grant = {{(NREQ-1){1'b0}}, 1'b1} << w_pick_sel;

  // Priority moves to the lane just after the one being served
  always_comb begin
    if (r_sel == SEL_LAST) begin
      w_ptr_next = '0;
    end else begin
      w_ptr_next = r_sel + SELW'(1'b1);
    end
  end

  // Sequencer: ownership, start pulse, done/timeout wait and completion
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_timer <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick_grant;
            r_sel   <= w_pick_sel;
            r_state <= S_START;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_START: begin
          r_timer <= '0;
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          r_timer <= r_timer + TW'(1'b1);
          // A done arriving on the last allowed cycle still counts as success
          if (i_hash_done) begin
            r_err   <= 1'b0;
            r_state <= S_DONE;
          end else if (r_timer == TIMER_LAST) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_BUSY;
          end
        end
        S_DONE: begin
          r_ptr   <= w_ptr_next;
          r_grant <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_grant <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_grant       = r_grant;
  assign o_sel         = r_sel;
  assign o_hash_start  = (r_state == S_START);
  assign o_busy        = (r_state != S_IDLE);
  assign o_ack         = (r_state == S_DONE) ? r_grant : '0;
  assign o_timeout_err = (r_state == S_DONE) & r_err;

endmodule
